pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_ctrl_wdog.sv | 30 +++
 rtl/pipe_ctrl.sv | 82 ++++++++
 tb/tb_pipe_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall vectors, exception codes, FSM states.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W = 6;
  localparam int unsigned XLEN    = 32;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  localparam logic [XLEN-1:0] EXC_NONE = 32'h0000_0000;
  localparam logic [XLEN-1:0] EXC_ERET = 32'h0000_000e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_REFILL = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Stall watchdog: counts consecutive stalled cycles and raises a sticky error at LIMIT.
module pipe_wdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic err
);

  localparam int unsigned CLOG  = $clog2(LIMIT + 1);
  localparam int unsigned CNT_W = (CLOG < 8) ? 8 : CLOG;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt;

  // Saturating run-length counter; error latches on the increment that reaches the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (!active) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
      if (cnt == CNT_MAX - CNT_W'(1)) err <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with exception redirect.
// Define PIPE_STALL_WDOG_EN to build in the consecutive-stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int unsigned WDOG_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        wdog_err_o
);

  ctrl_state_e       state;
  logic [STALL_W-1:0] run_stall;
  logic               exc_take;

  // Deepest requesting stage wins; holding a stage also holds everything upstream.
  always_comb begin
    run_stall = STALL_NONE;
    if (stallreq_mem)     run_stall = STALL_MEM;
    else if (stallreq_ex) run_stall = STALL_EX;
    else if (stallreq_id) run_stall = STALL_ID;
  end

  assign stall_o  = (!rst && state == ST_RUN) ? run_stall : STALL_NONE;
  assign exc_take = (state == ST_RUN) && (excepttype_i != EXC_NONE) && !stallreq_mem;

  // Exceptions wait for the memory stage to finish its bus cycle before redirecting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      flush_o  <= 1'b0;
      new_pc_o <= 32'h0;
    end else begin
      case (state)
        ST_RUN: begin
          if (exc_take) begin
            state    <= ST_FLUSH;
            flush_o  <= 1'b1;
            new_pc_o <= (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
          end
        end
        ST_FLUSH: begin
          state   <= ST_REFILL;
          flush_o <= 1'b0;
        end
        ST_REFILL: begin
          state <= ST_RUN;
        end
        default: begin
          state   <= ST_RUN;
          flush_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_WDOG_EN
  pipe_wdog #(
    .LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .active (stall_o != STALL_NONE),
    .err    (wdog_err_o)
  );
`else
  logic unused_wdog_limit;
  assign unused_wdog_limit = ^WDOG_LIMIT;
  assign wdog_err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: per-cycle expectations queued at drive time, checked mid-cycle.
module tb_pipe_ctrl;

`ifdef PIPE_STALL_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        wdog_err_o;

  typedef struct {
    string       tag;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        wdog;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pipe_ctrl #(
    .EXC_VECTOR (32'h0000_0020),
    .WDOG_LIMIT (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excepttype_i (excepttype_i),
    .cp0_epc_i    (cp0_epc_i),
    .stall_o      (stall_o),
    .flush_o      (flush_o),
    .new_pc_o     (new_pc_o),
    .wdog_err_o   (wdog_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs from a negedge and queue what the outputs must be in that cycle.
  task automatic cyc(input string tag, input logic id, input logic ex, input logic mem,
                     input logic [31:0] exc, input logic [31:0] epc,
                     input logic [5:0] es, input logic ef, input logic [31:0] ep, input logic ew);
    exp_t e;
    stallreq_id  = id;
    stallreq_ex  = ex;
    stallreq_mem = mem;
    excepttype_i = exc;
    cp0_epc_i    = epc;
    e.tag = tag; e.stall = es; e.flush = ef; e.pc = ep; e.wdog = ew;
    sb.push_back(e);
    @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".stall"}, 32'(stall_o), 32'(e.stall));
      chk({e.tag, ".flush"}, 32'(flush_o), 32'(e.flush));
      chk({e.tag, ".pc"},    new_pc_o,     e.pc);
      chk({e.tag, ".wdog"},  32'(wdog_err_o), 32'(e.wdog));
    end
  end

  initial begin : timeout
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    stallreq_id = 1'b1; stallreq_ex = 1'b1; stallreq_mem = 1'b1;
    excepttype_i = 32'h8; cp0_epc_i = 32'h0;
    #3;
    chk("rst.stall", 32'(stall_o), 32'h0);
    chk("rst.flush", 32'(flush_o), 32'h0);
    chk("rst.pc",    new_pc_o,     32'h0);
    chk("rst.wdog",  32'(wdog_err_o), 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    //   tag         id ex mem exc    epc           stall      flush pc            wdog
    cyc("idle",      0, 0, 0, 32'h0, 32'h0,        6'b000000, 0, 32'h0,        0);
    cyc("id",        1, 0, 0, 32'h0, 32'h0,        6'b000111, 0, 32'h0,        0);
    cyc("idex",      1, 1, 0, 32'h0, 32'h0,        6'b001111, 0, 32'h0,        0);
    cyc("idexmem",   1, 1, 1, 32'h0, 32'h0,        6'b011111, 0, 32'h0,        0);
    cyc("idle2",     0, 0, 0, 32'h0, 32'h0,        6'b000000, 0, 32'h0,        0);
    cyc("exc8",      0, 0, 0, 32'h8, 32'h0,        6'b000000, 0, 32'h0,        0);
    cyc("flush8",    1, 0, 0, 32'h0, 32'h0,        6'b000000, 1, 32'h20,       0);
    cyc("refill8",   1, 0, 0, 32'h0, 32'h0,        6'b000000, 0, 32'h20,       0);
    cyc("run8",      1, 0, 0, 32'h0, 32'h0,        6'b000111, 0, 32'h20,       0);
    cyc("eret",      0, 0, 0, 32'he, 32'h1234,     6'b000000, 0, 32'h20,       0);
    cyc("flushe",    0, 0, 0, 32'h0, 32'h5555,     6'b000000, 1, 32'h1234,     0);
    cyc("refill_ig", 0, 0, 0, 32'hc, 32'h5555,     6'b000000, 0, 32'h1234,     0);
    cyc("run_hold",  0, 0, 0, 32'h0, 32'h5555,     6'b000000, 0, 32'h1234,     0);
    cyc("defer1",    0, 0, 1, 32'hc, 32'h0,        6'b011111, 0, 32'h1234,     0);
    cyc("defer2",    0, 0, 1, 32'hc, 32'h0,        6'b011111, 0, 32'h1234,     0);
    cyc("defer3",    0, 0, 1, 32'hc, 32'h0,        6'b011111, 0, 32'h1234,     0);
    cyc("take_c",    0, 0, 0, 32'hc, 32'h0,        6'b000000, 0, 32'h1234,     0);

    // Reset lands in the middle of the FLUSH cycle.
    stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
    excepttype_i = 32'h0;
    begin
      exp_t e;
      e.tag = "flushc"; e.stall = 6'b000000; e.flush = 1'b1; e.pc = 32'h20; e.wdog = 1'b0;
      sb.push_back(e);
    end
    #4;
    rst = 1'b1;
    stallreq_id = 1'b1;
    #1;
    chk("midrst.flush", 32'(flush_o), 32'h0);
    chk("midrst.pc",    new_pc_o,     32'h0);
    chk("midrst.stall", 32'(stall_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    cyc("post_rst",  1, 0, 0, 32'h0, 32'h0,        6'b000111, 0, 32'h0,        0);
    cyc("wd_clr",    0, 0, 0, 32'h0, 32'h0,        6'b000000, 0, 32'h0,        0);
    cyc("wd1",       0, 1, 0, 32'h0, 32'h0,        6'b001111, 0, 32'h0,        0);
    cyc("wd2",       0, 1, 0, 32'h0, 32'h0,        6'b001111, 0, 32'h0,        0);
    cyc("wd3",       0, 1, 0, 32'h0, 32'h0,        6'b001111, 0, 32'h0,        0);
    cyc("wd4",       0, 1, 0, 32'h0, 32'h0,        6'b001111, 0, 32'h0,        0);
    cyc("wd_set",    0, 0, 0, 32'h0, 32'h0,        6'b000000, 0, 32'h0,        WD);
    cyc("wd_stick",  0, 0, 0, 32'h0, 32'h0,        6'b000000, 0, 32'h0,        WD);

    rst = 1'b1;
    #1;
    chk("wd_rst", 32'(wdog_err_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #5;
    chk("sb_drain", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
